imm_gen_stage: RTL
==================

# imm_gen_stage

Pipelined, parametrised immediate generator for the BFNP decode path. It takes a raw instruction word plus an immediate-format select and returns the sign- or zero-extended immediate one cycle later behind a valid/ready handshake. Compared with the earlier purely combinational generator, it adds:
- XLEN 32/64 support;
- CSR zimm and RV64 6-bit shamt;
- optional RVC immediate formats (CI, CJ, CB);
- illegal-select flagging;
- a full-throughput skid buffer and a flush input, so it can sit between decode and rename without combinational ready paths.

## Interface
Parameters:
- XLEN, 32, datapath width; legal values are 32 or 64.
- TAG_W, 8, width of the sideband tag carried alongside the data (ROB index / PC tag).
- RVC_EN, 1, enables the compressed formats (sel 8–10).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  input word valid.
- in_ready  out  1  stage can accept; registered.
- in_inst  in  32  full instruction word (RVC in bits [15:0]).
- in_sel  in  4  immediate format select.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  output valid.
- out_ready  in  1  downstream accepts.
- out_imm  out  XLEN  generated immediate.
- out_tag  out  TAG_W  tag matching out_imm.
- out_illegal  out  1  select code unsupported.

## Operation
Formats are listed by in_sel. "sext" sign-extends to XLEN; "zext" zero-extends. Bit indices refer to in_inst.
- 0 NONE: 0.
- 1 I: sext(inst[31:20]).
- 2 SHAMT: zext(inst[24:20]) when XLEN=32; zext(inst[25:20]) when XLEN=64.
- 3 S: sext({inst[31:25],inst[11:7]}).
- 4 B: sext({inst[31],inst[7],inst[30:25],inst[11:8],0}).
- 5 U: sext({inst[31:12],12'b0}). This is negative on RV64 when inst[31]=1.
- 6 J: sext({inst[31],inst[19:12],inst[20],inst[30:21],0}).
- 7 ZIMM: zext(inst[19:15]).
- 8 CI: sext({inst[12],inst[6:2]}).
- 9 CJ: sext({inst[12],inst[8],inst[10:9],inst[6],inst[7],inst[2],inst[11],inst[5:3],0}).
- 10 CB: sext({inst[12],inst[6:5],inst[2],inst[11:10],inst[4:3],0}).
- Illegal select: codes 11–15, or codes 8–10 with RVC_EN=0. Result is out_imm=0 and out_illegal=1; the word still flows through the pipeline normally.

Buffering uses two entries: main and skid.
- States: EMPTY (no entry valid), ONE (main valid), TWO (main and skid valid).
- out_valid = main valid. in_ready = !skid_valid.
- A transfer occurs on a cycle where valid and ready are both high, on each side independently.
- EMPTY: an input transfer moves to ONE.
- ONE:
  - Input transfer with output transfer: stay in ONE; main loads the new word.
  - Input transfer without output transfer: move to TWO; skid loads the new word.
  - Output transfer only: move to EMPTY.
- TWO: in_ready=0. An output transfer moves the skid entry to main and returns to ONE.
- Ordering is strictly FIFO. No word is dropped or duplicated.
- out_imm, out_tag and out_illegal hold stable while out_valid && !out_ready.
- flush:
  - Next state is EMPTY regardless of the handshakes.
  - An input accepted in the flush cycle is discarded.
  - flush has priority over all transfers.

## Timing
- Reset values: out_valid=0, out_imm=0, out_tag=0, out_illegal=0, skid empty, in_ready=1 (also asserted while rst_n is low).
- Latency: an input accepted at edge N is presented with out_valid=1 after edge N, provided the stage was EMPTY or draining.
- Throughput: one word per cycle while out_ready is held high.
- in_ready depends only on flops; it has no combinational path from out_ready.
- Reset asserted mid-operation clears all entries immediately (asynchronous). Outputs return to their reset values without waiting for a clock edge.
- After flush asserted at edge N: out_valid=0 and in_ready=1 from edge N+1.

## Structure
- imm_pkg holds:
  - imm_sel_e enum (codes 0–10 as above);
  - the IMM_SEL_W=4 constant;
  - skid state enum (EMPTY, ONE, TWO);
  - an elaboration check function rejecting XLEN values other than 32 or 64.
- Sub-module imm_decode: purely combinational. Parameters XLEN and RVC_EN; inputs inst and sel; outputs imm and illegal. It is instantiated once on the input side, so both buffer entries store decoded values.
- imm_gen_stage contains the skid buffer, flush and state logic.

## Test plan
- I-format, XLEN=32: inst=0xFFF00093, sel=1, out_ready=1. Required: out_imm=0xFFFFFFFF one cycle later, out_illegal=0.
- B-format: inst=0xFE000EE3, sel=4. Required: out_imm=0xFFFFFFFC. With tag=0x5A, out_tag=0x5A.
- U-format, XLEN=64: inst=0x800002B7, sel=5. Required: out_imm=0xFFFFFFFF80000000. Same inst with sel=2 required: out_imm=0x00 (shamt field [25:20]=0).
- RVC and illegal codes:
  - RVC_EN=1, inst=0x000010FD, sel=8: out_imm=0xFFFFFFFF.
  - RVC_EN=0, same stimulus: out_imm=0, out_illegal=1.
  - sel=12 with any RVC_EN: out_illegal=1.
- Backpressure: stream tags 1..6 with in_valid=1 while holding out_ready=0 for 3 cycles.
  - in_ready drops after the second accept.
  - After out_ready rises, outputs are 1..6 in order with none lost.
- Flush and reset: fill both entries, then assert flush with in_valid=1.
  - Next cycle: out_valid=0, in_ready=1, and the flush-cycle input never appears at the output.
  - Repeat with rst_n pulsed low mid-stream: outputs are at reset values immediately.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared types and constants for the immediate-generator stage.
//   imm_sel_e      : immediate format select codes (0-10; 11-15 are illegal)
//   IMM_SEL_W      : width of the format select
//   skid_state_e   : occupancy of the two-entry main/skid buffer
//   xlen_is_legal  : elaboration-time guard on the datapath width
package imm_pkg;

  localparam int unsigned IMM_SEL_W = 4;

  typedef enum logic [IMM_SEL_W-1:0] {
    IMM_NONE  = 4'd0,
    IMM_I     = 4'd1,
    IMM_SHAMT = 4'd2,
    IMM_S     = 4'd3,
    IMM_B     = 4'd4,
    IMM_U     = 4'd5,
    IMM_J     = 4'd6,
    IMM_ZIMM  = 4'd7,
    IMM_CI    = 4'd8,
    IMM_CJ    = 4'd9,
    IMM_CB    = 4'd10
  } imm_sel_e;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_e;

  function automatic bit xlen_is_legal(input int unsigned xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder.
//   inst    : 32-bit instruction word (compressed forms live in [15:0])
//   sel     : immediate format select (imm_sel_e encoding)
//   imm     : sign- or zero-extended immediate, XLEN wide (0 when illegal)
//   illegal : select code not supported by this configuration
module imm_decode
  import imm_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter bit          RVC_EN = 1'b1
) (
  input  logic [31:0]          inst,
  input  logic [IMM_SEL_W-1:0] sel,
  output logic [XLEN-1:0]      imm,
  output logic                 illegal
);

  // The two opcode-size bits never feed any immediate field.
  logic w_unused_lsb;
  assign w_unused_lsb = ^inst[1:0];

  // A size cast of a $signed operand sign-extends; of an unsigned operand it
  // zero-extends. That gives sext/zext for any XLEN without zero-width
  // replications.
  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    case (sel)
      IMM_NONE:  imm = '0;
      IMM_I:     imm = XLEN'($signed(inst[31:20]));
      IMM_SHAMT: begin
        if (XLEN == 64) imm = XLEN'(inst[25:20]);
        else            imm = XLEN'(inst[24:20]);
      end
      IMM_S:     imm = XLEN'($signed({inst[31:25], inst[11:7]}));
      IMM_B:     imm = XLEN'($signed({inst[31], inst[7], inst[30:25],
                                      inst[11:8], 1'b0}));
      IMM_U:     imm = XLEN'($signed({inst[31:12], 12'b0}));
      IMM_J:     imm = XLEN'($signed({inst[31], inst[19:12], inst[20],
                                      inst[30:21], 1'b0}));
      IMM_ZIMM:  imm = XLEN'(inst[19:15]);
      IMM_CI: begin
        if (RVC_EN) imm = XLEN'($signed({inst[12], inst[6:2]}));
        else        illegal = 1'b1;
      end
      IMM_CJ: begin
        if (RVC_EN) imm = XLEN'($signed({inst[12], inst[8], inst[10:9],
                                         inst[6], inst[7], inst[2],
                                         inst[11], inst[5:3], 1'b0}));
        else        illegal = 1'b1;
      end
      IMM_CB: begin
        if (RVC_EN) imm = XLEN'($signed({inst[12], inst[6:5], inst[2],
                                         inst[11:10], inst[4:3], 1'b0}));
        else        illegal = 1'b1;
      end
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Pipelined immediate generator with a two-entry skid buffer.
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   flush               : synchronous flush; empties both entries, drops input
//   in_valid/in_ready   : input handshake (in_ready is a decode of state flops)
//   in_inst/in_sel/in_tag : instruction word, format select, sideband tag
//   out_valid/out_ready : output handshake
//   out_imm/out_tag/out_illegal : decoded immediate, tag, illegal-select flag
module imm_gen_stage
  import imm_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned TAG_W  = 8,
  parameter bit          RVC_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_inst,
  input  logic [IMM_SEL_W-1:0] in_sel,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_imm,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 out_illegal
);

  if (!xlen_is_legal(XLEN)) begin : g_bad_xlen
    $error("imm_gen_stage: XLEN must be 32 or 64");
  end

  skid_state_e r_state;
  skid_state_e w_state_nxt;

  logic [XLEN-1:0]  r_main_imm;
  logic [TAG_W-1:0] r_main_tag;
  logic             r_main_ill;
  logic [XLEN-1:0]  r_skid_imm;
  logic [TAG_W-1:0] r_skid_tag;
  logic             r_skid_ill;

  logic [XLEN-1:0]  w_dec_imm;
  logic             w_dec_ill;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic             w_load_main_in;
  logic             w_load_main_skid;
  logic             w_load_skid;

  // Decoding happens before the buffer so both entries hold final values.
  imm_decode #(
    .XLEN   (XLEN),
    .RVC_EN (RVC_EN)
  ) u_decode (
    .inst    (in_inst),
    .sel     (in_sel),
    .imm     (w_dec_imm),
    .illegal (w_dec_ill)
  );

  assign in_ready    = (r_state != SKID_TWO);
  assign out_valid   = (r_state != SKID_EMPTY);
  assign out_imm     = r_main_imm;
  assign out_tag     = r_main_tag;
  assign out_illegal = r_main_ill;

  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = out_valid && out_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (flush) begin
      w_state_nxt = SKID_EMPTY;
    end else begin
      case (r_state)
        SKID_EMPTY: begin
          if (w_in_xfer) begin
            w_state_nxt    = SKID_ONE;
            w_load_main_in = 1'b1;
          end
        end
        SKID_ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            w_load_main_in = 1'b1;
          end else if (w_in_xfer) begin
            w_state_nxt = SKID_TWO;
            w_load_skid = 1'b1;
          end else if (w_out_xfer) begin
            w_state_nxt = SKID_EMPTY;
          end
        end
        SKID_TWO: begin
          if (w_out_xfer) begin
            w_state_nxt      = SKID_ONE;
            w_load_main_skid = 1'b1;
          end
        end
        default: w_state_nxt = SKID_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= SKID_EMPTY;
      r_main_imm <= '0;
      r_main_tag <= '0;
      r_main_ill <= 1'b0;
      r_skid_imm <= '0;
      r_skid_tag <= '0;
      r_skid_ill <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_main_in) begin
        r_main_imm <= w_dec_imm;
        r_main_tag <= in_tag;
        r_main_ill <= w_dec_ill;
      end else if (w_load_main_skid) begin
        r_main_imm <= r_skid_imm;
        r_main_tag <= r_skid_tag;
        r_main_ill <= r_skid_ill;
      end
      if (w_load_skid) begin
        r_skid_imm <= w_dec_imm;
        r_skid_tag <= in_tag;
        r_skid_ill <= w_dec_ill;
      end
    end
  end

endmodule
